// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory read port between the fetch front end (master) and IM (slave).
// In-order requests with a valid/ready handshake; responses return in request order.
interface if_prefetch_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Fetch-stage prefetch queue: credit-limited in-order IM reads, PC-tagged FIFO, redirect flush.
// Optional macro IFQ_BYPASS_EN lets a response reach instr_0/pc_0 in its own cycle when the queue is empty.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset,
  if_prefetch_queue_if.master   imem,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  valid_0,
  output logic [31:0]           instr_0,
  output logic [31:0]           pc_0,
  output logic [31:0]           pc4_0
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  // Storage
  entry_t      q_mem   [DEPTH];
  logic [31:0] tag_mem [DEPTH];

  // State
  ptr_t        q_head, q_tail;
  ptr_t        tag_head, tag_tail;
  cnt_t        count, inflight, drop;
  logic [31:0] fetch_pc;
  logic [31:0] pc_hold;

  // Datapath decisions
  logic [CW:0] credit_used;
  logic        fire;
  logic        rsp_acc;
  logic        rsp_keep;
  logic        q_valid;
  logic        byp_hit;
  logic        pop_q;
  logic        push;
  logic [31:0] rsp_pc;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credits cover queued plus in-flight words, so a returning word always has a slot.
  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign imem.req_valid = reset & ~redirect & (credit_used < (CW+1)'(DEPTH));
  assign imem.req_addr  = fetch_pc;
  assign fire           = imem.req_valid & imem.req_ready;

  // A response with nothing outstanding is spurious and must not underflow the counters.
  assign rsp_acc  = reset & imem.rsp_valid & (inflight != '0);
  assign rsp_keep = rsp_acc & (drop == '0) & ~redirect;
  assign rsp_pc   = tag_mem[tag_head];
  assign q_valid  = (count != '0);

`ifdef IFQ_BYPASS_EN
  assign byp_hit = rsp_keep & ~q_valid;
`else
  assign byp_hit = 1'b0;
`endif

  assign pop_q = q_valid & ~stall & ~redirect;
  // A bypassed word consumed this cycle never occupies a slot.
  assign push  = rsp_keep & ~(byp_hit & ~stall);

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    valid_0 = 1'b0;
    instr_0 = 32'h0000_0000;
    pc_0    = pc_hold;
    if (q_valid) begin
      valid_0 = 1'b1;
      instr_0 = q_mem[q_head].instr;
      pc_0    = q_mem[q_head].pc;
    end else if (byp_hit) begin
      valid_0 = 1'b1;
      instr_0 = imem.rsp_data;
      pc_0    = rsp_pc;
    end
  end

  assign pc4_0 = pc_0 + 32'd4;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      pc_hold  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      tag_head <= '0;
      tag_tail <= '0;
    end else begin
      pc_hold  <= pc_0;
      inflight <= inflight + cnt_t'(fire) - cnt_t'(rsp_acc);
      // Tags track every outstanding request, stale or not, so they survive a redirect.
      if (fire) begin
        tag_tail <= tag_tail + ptr_t'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_acc) begin
        tag_head <= tag_head + ptr_t'(1);
      end
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= '0;
        q_tail   <= q_head;
        drop     <= inflight - cnt_t'(rsp_acc);
      end else begin
        count <= count + cnt_t'(push) - cnt_t'(pop_q);
        if (push) begin
          q_tail <= q_tail + ptr_t'(1);
        end
        if (pop_q) begin
          q_head <= q_head + ptr_t'(1);
        end
        if (rsp_acc && (drop != '0)) begin
          drop <= drop - cnt_t'(1);
        end
      end
    end
  end

  // NOTE: storage arrays are not reset; occupancy counters and pointers alone
  // decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (fire) begin
      tag_mem[tag_tail] <= fetch_pc;
    end
    if (push) begin
      q_mem[q_tail] <= '{instr: imem.rsp_data, pc: rsp_pc};
    end
  end

  a_credit_bound : assert property (@(posedge clk) disable iff (!reset)
    credit_used <= (CW+1)'(DEPTH));
  a_drop_bound : assert property (@(posedge clk) disable iff (!reset)
    drop <= inflight);
  a_addr_stable : assert property (@(posedge clk) disable iff (!reset)
    (imem.req_valid && !imem.req_ready && !redirect) |=> (imem.req_addr == $past(imem.req_addr)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: in-order IM model with latency and response gating,
// scoreboard of expected fetch PCs popped by a monitor whenever the F/D register takes a word.
module tb_if_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid_0;
  logic [31:0] instr_0;
  logic [31:0] pc_0;
  logic [31:0] pc4_0;

  if_prefetch_queue_if imem();

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_0     (valid_0),
    .instr_0     (instr_0),
    .pc_0        (pc_0),
    .pc4_0       (pc4_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pops   = 0;
  int fires  = 0;
  int cyc    = 0;

  // IM model configuration
  int lat         = 1;
  bit hold        = 1'b0;
  int rsp_credit  = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return 32'h2401_0001 + ((a - 32'h0000_3000) >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Requests are sampled mid-cycle, where all inputs and outputs are settled.
  always @(negedge clk) begin
    if (reset && imem.req_valid && imem.req_ready) begin
      pend_q.push_back('{addr: imem.req_addr, due: cyc + lat});
      fires++;
    end
  end

  always @(posedge clk) begin
    cyc++;
    #2;
    imem.rsp_valid = 1'b0;
    if (!reset) begin
      pend_q.delete();
    end else if (pend_q.size() != 0 && pend_q[0].due <= cyc && (!hold || rsp_credit > 0)) begin
      if (hold) rsp_credit--;
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = im_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  // Monitor: every word the F/D register takes must be the next expected PC.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_0 && !stall && !redirect) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h, want no pop", pc_0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("pop_pc", pc_0, e);
          check("pop_instr", instr_0, im_word(e));
          check("pop_pc4", pc4_0, e + 32'd4);
        end
      end else if (!valid_0) begin
        check("nop_instr", instr_0, 32'h0000_0000);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_stream(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    step(2);
    @(negedge clk);
    check("rst_req_valid", 32'(imem.req_valid), 32'd0);
    check("rst_valid_0", 32'(valid_0), 32'd0);
    check("rst_instr_0", instr_0, 32'h0000_0000);
    check("rst_pc_0", pc_0, 32'h0000_3000);
    check("rst_pc4_0", pc4_0, 32'h0000_3004);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int p0;
    int f0;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    imem.req_ready = 1'b1;

    // Streaming from reset, latency 1
    lat = 1; hold = 1'b0; stall = 1'b0; imem.req_ready = 1'b1;
    do_reset();
    set_stream(32'h3000, 32);
    p0 = pops;
    @(negedge clk);
    check("t1_first_addr", imem.req_addr, 32'h0000_3000);
    step(10);
    check("t1_pops", 32'(pops - p0), 32'd8);

    // IM not ready for 3 cycles: address held, fires on the 4th
    imem.req_ready = 1'b0;
    do_reset();
    set_stream(32'h3000, 32);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_wait_valid", 32'(imem.req_valid), 32'd1);
      check("t4_wait_addr", imem.req_addr, 32'h0000_3000);
      step(1);
    end
    imem.req_ready = 1'b1;
    @(negedge clk);
    check("t4_fire_valid", 32'(imem.req_valid), 32'd1);
    check("t4_fire_addr", imem.req_addr, 32'h0000_3000);
    step(1);
    imem.req_ready = 1'b0;
    @(negedge clk);
    check("t4_next_addr", imem.req_addr, 32'h0000_3004);
    step(1);
    imem.req_ready = 1'b1;
    p0 = pops;
    step(8);
    check("t4_pops_ok", 32'(pops - p0 >= 4), 32'd1);

    // Stall from reset fills exactly DEPTH credits
    stall = 1'b1;
    do_reset();
    f0 = fires;
    step(10);
    @(negedge clk);
    check("t2_fires", 32'(fires - f0), 32'd4);
    check("t2_req_valid", 32'(imem.req_valid), 32'd0);
    check("t2_valid_0", 32'(valid_0), 32'd1);
    check("t2_pc_0", pc_0, 32'h0000_3000);
    check("t2_instr_0", instr_0, 32'h2401_0001);
    set_stream(32'h3000, 32);
    step(1);
    stall = 1'b0;
    p0 = pops;
    step(8);
    check("t2_pops", 32'(pops - p0), 32'd8);

    // Redirect with two words queued and two in flight
    stall = 1'b1; hold = 1'b1; rsp_credit = 0;
    do_reset();
    step(6);
    rsp_credit = 2;
    step(6);
    @(negedge clk);
    check("t3_pre_valid_0", 32'(valid_0), 32'd1);
    check("t3_pre_pc_0", pc_0, 32'h0000_3000);
    check("t3_pre_req_valid", 32'(imem.req_valid), 32'd0);
    step(1);
    set_stream(32'h3100, 32);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3101;
    @(negedge clk);
    check("t3_redir_req_valid", 32'(imem.req_valid), 32'd0);
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t3_flush_valid_0", 32'(valid_0), 32'd0);
    check("t3_hold_pc_0", pc_0, 32'h0000_3000);
    check("t3_new_req_valid", 32'(imem.req_valid), 32'd1);
    check("t3_new_addr", imem.req_addr, 32'h0000_3100);
    step(1);
    hold  = 1'b0;
    stall = 1'b0;
    p0 = pops;
    step(12);
    check("t3_pops_ok", 32'(pops - p0 >= 5), 32'd1);

    // Redirect and stall together with a full queue
    stall = 1'b1; hold = 1'b0; lat = 1;
    do_reset();
    step(10);
    @(negedge clk);
    check("t5_full_req_valid", 32'(imem.req_valid), 32'd0);
    check("t5_full_valid_0", 32'(valid_0), 32'd1);
    step(1);
    set_stream(32'h4000, 32);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4000;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t5_flush_valid_0", 32'(valid_0), 32'd0);
    check("t5_flush_instr_0", instr_0, 32'h0000_0000);
    check("t5_hold_pc_0", pc_0, 32'h0000_3000);
    step(1);
    stall = 1'b0;
    p0 = pops;
    step(10);
    check("t5_pops_ok", 32'(pops - p0 >= 6), 32'd1);

    // Single response into an empty queue
    stall = 1'b0; hold = 1'b1; rsp_credit = 0;
    do_reset();
    set_stream(32'h3000, 32);
    step(6);
    rsp_credit = 1;
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    check("t6_byp_valid_0", 32'(valid_0), 32'd1);
    check("t6_byp_instr_0", instr_0, 32'h2401_0001);
    check("t6_byp_pc_0", pc_0, 32'h0000_3000);
    step(1);
    @(negedge clk);
    check("t6_after_valid_0", 32'(valid_0), 32'd0);
`else
    check("t6_same_valid_0", 32'(valid_0), 32'd0);
    step(1);
    @(negedge clk);
    check("t6_next_valid_0", 32'(valid_0), 32'd1);
    check("t6_next_instr_0", instr_0, 32'h2401_0001);
    check("t6_next_pc_0", pc_0, 32'h0000_3000);
`endif
    step(1);
    hold = 1'b0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
